pipe_skid_reg: RTL and testbench



---
 rtl/pipe_skid_pkg.sv | 22 ++
 rtl/flopenr_s.sv | 21 ++
 rtl/pipe_skid_reg.sv | 123 ++++++++++++
 tb/tb_pipe_skid_reg.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/pipe_skid_pkg.sv
// Shared types and constants for the pipe_skid_reg stage register.
package pipe_skid_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } skid_state_t;

  localparam int unsigned SKID_DEPTH = 2;
  localparam int unsigned CNT_W      = $clog2(SKID_DEPTH + 1);

  // Occupancy implied by a state encoding.
  function automatic logic [CNT_W-1:0] state_count(input skid_state_t s);
    case (s)
      BUSY:    state_count = CNT_W'(1);
      FULL:    state_count = CNT_W'(2);
      default: state_count = CNT_W'(0);
    endcase
  endfunction

endpackage

// File: rtl/flopenr_s.sv
// N-bit register with load enable and synchronous active-high reset to zero.
module flopenr_s #(
  parameter int unsigned N = 64
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_en,
  input  logic [N-1:0] i_d,
  output logic [N-1:0] o_q
);

  logic [N-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_reset)   r_q <= '0;
    else if (i_en) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake and two-entry skid buffer.
// Optional synchronous flush port is enabled by defining PIPE_SKID_FLUSH_EN.
module pipe_skid_reg
  import pipe_skid_pkg::*;
#(
  parameter int unsigned N = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
`ifdef PIPE_SKID_FLUSH_EN
  input  logic             flush,
`endif
  output logic [CNT_W-1:0] count
);

  skid_state_t      r_state;
  skid_state_t      w_state_nxt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_count;

  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_flush;
  logic             w_main_en;
  logic             w_skid_en;
  logic             w_main_sel_skid;
  logic [N-1:0]     w_main_d;
  logic [N-1:0]     w_skid_q;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;

`ifdef PIPE_SKID_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // Next state and register load enables.
  always_comb begin
    w_state_nxt     = r_state;
    w_main_en       = 1'b0;
    w_skid_en       = 1'b0;
    w_main_sel_skid = 1'b0;
    unique case (r_state)
      EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt = BUSY;
          w_main_en   = 1'b1;
        end
      end
      BUSY: begin
        if (w_in_fire && w_out_fire) begin
          w_main_en = 1'b1;
        end else if (w_in_fire) begin
          w_state_nxt = FULL;
          w_skid_en   = 1'b1;
        end else if (w_out_fire) begin
          w_state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (w_out_fire) begin
          w_state_nxt     = BUSY;
          w_main_en       = 1'b1;
          w_main_sel_skid = 1'b1;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
    // Flush drops everything in flight, including a same-cycle input.
    if (w_flush) begin
      w_state_nxt = EMPTY;
      w_main_en   = 1'b0;
      w_skid_en   = 1'b0;
    end
  end

  // State plus handshake/occupancy outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_count     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != FULL);
      r_out_valid <= (w_state_nxt != EMPTY);
      r_count     <= state_count(w_state_nxt);
    end
  end

  assign w_main_d = w_main_sel_skid ? w_skid_q : in_data;

  flopenr_s #(.N(N)) u_main (
    .i_clk   (clk),
    .i_reset (reset),
    .i_en    (w_main_en),
    .i_d     (w_main_d),
    .o_q     (out_data)
  );

  flopenr_s #(.N(N)) u_skid (
    .i_clk   (clk),
    .i_reset (reset),
    .i_en    (w_skid_en),
    .i_d     (in_data),
    .o_q     (w_skid_q)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign count     = r_count;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: directed scenarios plus random stress.
module tb_pipe_skid_reg;

  localparam int unsigned N = 64;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic [1:0]   count;
`ifdef PIPE_SKID_FLUSH_EN
  logic         flush;
`endif

  logic [N-1:0] sb[$];
  int           n_checks;
  int           n_errors;

  pipe_skid_reg #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef PIPE_SKID_FLUSH_EN
    .flush     (flush),
`endif
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, score the handshakes, clock, then check state.
  task automatic step(input logic v, input logic [N-1:0] d, input logic r,
                      input logic f, input logic rst);
    logic [N-1:0] exp;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    reset     = rst;
`ifdef PIPE_SKID_FLUSH_EN
    flush     = f;
`endif
    #1;
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_out", out_data, 64'hDEAD_DEAD_DEAD_DEAD);
        end else begin
          exp = sb.pop_front();
          check_eq("out_data", out_data, exp);
        end
      end
      if (in_valid && in_ready && !f) sb.push_back(in_data);
      if (f) sb.delete();
    end else begin
      sb.delete();
    end
    @(posedge clk);
    @(negedge clk);
    check_eq("count", 64'(count), 64'(sb.size()));
    check_eq("in_ready", 64'(in_ready), 64'(sb.size() < 2));
    check_eq("out_valid", 64'(out_valid), 64'(sb.size() > 0));
    if (sb.size() > 0) check_eq("head", out_data, sb[0]);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; reset = 1'b1;
`ifdef PIPE_SKID_FLUSH_EN
    flush = 1'b0;
`endif
    @(negedge clk);

    // Reset then stream 1..4 at full rate.
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    check_eq("rst_out_data", out_data, 64'h0);
    check_eq("rst_count", 64'(count), 64'h0);
    check_eq("rst_in_ready", 64'(in_ready), 64'h1);
    for (int i = 1; i <= 4; i++) begin
      step(1, N'(i), 1, 0, 0);
      check_eq("stream_data", out_data, 64'(i));
      check_eq("stream_count", 64'(count), 64'h1);
    end
    step(0, '0, 1, 0, 0);

    // Stall absorption into the skid entry.
    step(1, N'('hA), 0, 0, 0);
    step(1, N'('hB), 0, 0, 0);
    check_eq("stall_count", 64'(count), 64'h2);
    check_eq("stall_in_ready", 64'(in_ready), 64'h0);
    step(1, N'('hC), 0, 0, 0);
    check_eq("stall_hold", out_data, 64'hA);
    step(0, '0, 1, 0, 0);
    check_eq("recover_in_ready", 64'(in_ready), 64'h1);
    check_eq("recover_data", out_data, 64'hB);
    step(0, '0, 1, 0, 0);

    // Simultaneous fire in BUSY.
    step(1, N'('h5), 0, 0, 0);
    step(1, N'('h6), 1, 0, 0);
    check_eq("simul_data", out_data, 64'h6);
    check_eq("simul_count", 64'(count), 64'h1);
    step(0, '0, 1, 0, 0);

    // Reset while FULL discards both entries.
    step(1, N'('h11), 0, 0, 0);
    step(1, N'('h22), 0, 0, 0);
    step(0, '0, 0, 0, 1);
    check_eq("midrst_count", 64'(count), 64'h0);
    check_eq("midrst_out_valid", 64'(out_valid), 64'h0);
    check_eq("midrst_out_data", out_data, 64'h0);
    check_eq("midrst_in_ready", 64'(in_ready), 64'h1);
    for (int i = 0; i < 3; i++) step(0, '0, 1, 0, 0);

`ifdef PIPE_SKID_FLUSH_EN
    // Flush from FULL with a competing input; then reset+flush together.
    step(1, N'('h31), 0, 0, 0);
    step(1, N'('h32), 0, 0, 0);
    step(1, N'('h33), 0, 1, 0);
    check_eq("flush_count", 64'(count), 64'h0);
    check_eq("flush_out_valid", 64'(out_valid), 64'h0);
    for (int i = 0; i < 3; i++) step(0, '0, 1, 0, 0);
    step(1, N'('h44), 0, 0, 0);
    step(1, N'('h55), 0, 1, 1);
    check_eq("rstflush_out_data", out_data, 64'h0);
    check_eq("rstflush_count", 64'(count), 64'h0);
    step(0, '0, 1, 0, 0);
`endif

    // Random stress against the scoreboard.
    for (int i = 0; i < 10000; i++) begin
      logic f;
      f = 1'b0;
`ifdef PIPE_SKID_FLUSH_EN
      f = ($urandom_range(0, 63) == 0);
`endif
      step(1'($urandom_range(0, 1)), {$urandom, $urandom},
           1'($urandom_range(0, 1)), f, 1'b0);
    end
    // Drain and confirm nothing remains or appears.
    for (int i = 0; i < 4; i++) step(0, '0, 1, 0, 0);
    check_eq("final_empty", 64'(sb.size()), 64'(count));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
